snoop_dispatch: RTL
===================

SNOOP_DISPATCH -- requirements
Module: snoop_dispatch

Interface
REQ-001 Parameter N_VMS, default 4: number of attached bpfvm instances (2..16).
REQ-002 Parameter SNOOP_FWD_ADDR_WIDTH, default 9: snooper/forwarder word address width.
REQ-003 Parameter DATA_WIDTH, default 64: snooper/forwarder data width.
REQ-004 Parameter PLEN_WIDTH, default SNOOP_FWD_ADDR_WIDTH+1: packet length width.
REQ-005 One clock; reset is asynchronous and active-high (ports clk, rst).
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 up_wr_addr / up_wr_data / up_wr_en / up_done  in  AW / DW / 1 / 1  upstream snooper write port; up_done is a 1-cycle pulse.
REQ-009 up_ready  out  1  a VM can accept the current or next snooped packet.
REQ-010 vm_wr_addr / vm_wr_data  out  N*AW / N*DW  per-VM write bus, flattened, VM i in slice i.
REQ-011 vm_wr_en / vm_done  out  N / N  per-VM write strobe and done pulse.
REQ-012 vm_ready_for_snooper  in  N  per-VM snooper ready.
REQ-013 vm_ready_for_forwarder  in  N  per-VM forwarder ready.
REQ-014 vm_len  in  N*PLEN_WIDTH  per-VM packet length to forwarder.
REQ-015 vm_rd_addr  out  AW  forwarder read address, broadcast to all VMs.
REQ-016 vm_rd_en / vm_fwd_done  out  N / N  per-VM read strobe and forwarder done pulse.
REQ-017 vm_rd_data  in  N*DW  per-VM read data, valid 1 cycle after vm_rd_en.
REQ-018 dn_rd_addr / dn_rd_en / dn_done  in  AW / 1 / 1  downstream forwarder port; dn_done is a 1-cycle pulse.
REQ-019 dn_rd_data / dn_ready / dn_len  out  DW / 1 / PLEN_WIDTH  downstream read data, ready, length.
REQ-020 pkt_in_cnt / pkt_out_cnt  out  32 / 32  dispatched and forwarded packet counts.

Function
REQ-021 Snoop FSM states: S_IDLE, S_LOCK; register s_lock (VM index) and s_ptr (round-robin start).
REQ-022 In S_IDLE, candidate = first i with vm_ready_for_snooper[i]=1, searching from s_ptr upward mod N_VMS; up_ready = OR of vm_ready_for_snooper.
REQ-023 In S_IDLE, up_wr_en=1 with a candidate SHALL route combinationally (zero latency) to that candidate, load s_lock, and enter S_LOCK.
REQ-024 In S_LOCK, all up_wr_* SHALL route to s_lock only; up_ready = vm_ready_for_snooper[s_lock].
REQ-025 up_done SHALL pulse vm_done[target] in the same cycle, set s_ptr = target+1 mod N_VMS, return to S_IDLE, increment pkt_in_cnt.
REQ-026 up_wr_en and up_done together in S_IDLE (1-beat packet) SHALL write and complete to the candidate, staying in S_IDLE.
REQ-027 up_done in S_IDLE with no write goes to the candidate (zero-length packet); up_wr_en/up_done with no candidate are dropped, no counter change.
REQ-028 Non-target vm_wr_en/vm_done SHALL be 0; vm_wr_addr/data broadcast upstream values.
REQ-029 Forward FSM states: F_IDLE, F_LOCK; registers f_lock, f_ptr.
REQ-030 In F_IDLE, if any vm_ready_for_forwarder, register the round-robin winner from f_ptr into f_lock and enter F_LOCK next cycle (1-cycle grant latency).
REQ-031 dn_ready = 1 only in F_LOCK; dn_len = vm_len[f_lock] while in F_LOCK.
REQ-032 In F_LOCK, vm_rd_en[f_lock] = dn_rd_en; vm_rd_addr = dn_rd_addr; dn_rd_data = vm_rd_data[f_lock] (1-cycle read latency preserved).
REQ-033 dn_done in F_LOCK SHALL pulse vm_fwd_done[f_lock] same cycle, set f_ptr = f_lock+1 mod N_VMS, enter F_IDLE, increment pkt_out_cnt.
REQ-034 f_lock SHALL hold until the next grant, so the read beat issued in the dn_done cycle returns correct data.
REQ-035 dn_done/dn_rd_en outside F_LOCK are ignored.
REQ-036 Counters SHALL wrap 2^32-1 -> 0; both FSMs operate concurrently, including on the same VM index.

Reset
REQ-037 rst SHALL force S_IDLE, F_IDLE, s_ptr=f_ptr=s_lock=f_lock=0, counters 0; vm_wr_en, vm_done, vm_rd_en, vm_fwd_done, dn_ready = 0.
REQ-038 Reset mid-packet abandons it: no vm_done or vm_fwd_done issued.

Verification
REQ-039 N=4, all VMs snoop-ready, four 3-beat packets -> delivered to VM0,1,2,3 in order, pkt_in_cnt=4.
REQ-040 Only VM2 ready, s_ptr=0 -> packet to VM2, s_ptr=3; next packet with VM0 ready -> VM0.
REQ-041 VM1 and VM3 forward-ready, f_ptr=0 -> dn_ready 1 cycle later, dn_len=vm_len[1]; after dn_done, VM3 granted next.
REQ-042 Single-beat packet (up_wr_en+up_done same cycle) -> vm_wr_en and vm_done on same VM same cycle, FSM stays S_IDLE.
REQ-043 No VM ready, up_wr_en pulsed -> all vm_wr_en 0, up_ready 0, pkt_in_cnt unchanged.
REQ-044 rst asserted mid 5-beat packet -> no vm_done, all outputs at reset values; next packet goes to VM0.

Source files
------------

// File: rtl/snoop_dispatch.sv
// snoop_dispatch: fans one upstream snooper out to N_VMS bpfvm instances and
// fans their forwarder ports back in to one downstream forwarder.
//
// Snoop path: the snooper write stream is routed with zero latency to a VM.
// The VM is picked round-robin among snoop-ready VMs on the first beat and
// locked until up_done.
// Forward path: a forward-ready VM is granted round-robin with one cycle of
// latency. It is then locked until dn_done.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   up_wr_addr/data/en       upstream snooper write beat
//   up_done                  end-of-packet pulse from the snooper
//   up_ready                 some VM can take the current or next packet
//   vm_wr_addr/data          per-VM write bus (broadcast), VM i in slice i
//   vm_wr_en, vm_done        per-VM write strobe and done pulse
//   vm_ready_for_snooper     per-VM snoop ready
//   vm_ready_for_forwarder   per-VM forward ready
//   vm_len                   per-VM packet length, VM i in slice i
//   vm_rd_addr               forwarder read address (broadcast)
//   vm_rd_en, vm_fwd_done    per-VM read strobe and forward-done pulse
//   vm_rd_data               per-VM read data, one cycle after vm_rd_en
//   dn_rd_addr/en, dn_done   downstream forwarder read request / done pulse
//   dn_rd_data/ready/len     downstream read data, ready, packet length
//   pkt_in_cnt, pkt_out_cnt  dispatched / forwarded packet counts (wrapping)
module snoop_dispatch #(
    parameter int unsigned N_VMS                = 4,
    parameter int unsigned SNOOP_FWD_ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH           = 64,
    parameter int unsigned PLEN_WIDTH           = SNOOP_FWD_ADDR_WIDTH + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // upstream snooper
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       up_wr_addr,
    input  logic [DATA_WIDTH-1:0]                 up_wr_data,
    input  logic                                  up_wr_en,
    input  logic                                  up_done,
    output logic                                  up_ready,
    // per-VM snoop side
    output logic [N_VMS*SNOOP_FWD_ADDR_WIDTH-1:0] vm_wr_addr,
    output logic [N_VMS*DATA_WIDTH-1:0]           vm_wr_data,
    output logic [N_VMS-1:0]                      vm_wr_en,
    output logic [N_VMS-1:0]                      vm_done,
    input  logic [N_VMS-1:0]                      vm_ready_for_snooper,
    // per-VM forward side
    input  logic [N_VMS-1:0]                      vm_ready_for_forwarder,
    input  logic [N_VMS*PLEN_WIDTH-1:0]           vm_len,
    output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       vm_rd_addr,
    output logic [N_VMS-1:0]                      vm_rd_en,
    output logic [N_VMS-1:0]                      vm_fwd_done,
    input  logic [N_VMS*DATA_WIDTH-1:0]           vm_rd_data,
    // downstream forwarder
    input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       dn_rd_addr,
    input  logic                                  dn_rd_en,
    input  logic                                  dn_done,
    output logic [DATA_WIDTH-1:0]                 dn_rd_data,
    output logic                                  dn_ready,
    output logic [PLEN_WIDTH-1:0]                 dn_len,
    // statistics
    output logic [31:0]                           pkt_in_cnt,
    output logic [31:0]                           pkt_out_cnt
);

    localparam int unsigned IDX_W = (N_VMS > 1) ? $clog2(N_VMS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {S_IDLE, S_LOCK} s_state_e;
    typedef enum logic {F_IDLE, F_LOCK} f_state_e;

    // Index + 1, wrapping at N_VMS (which need not be a power of two).
    function automatic idx_t inc_wrap(input idx_t i);
        if (int'(i) == int'(N_VMS) - 1) return '0;
        return i + idx_t'(1);
    endfunction

    // First requester at or after start, searching upward modulo N_VMS.
    function automatic idx_t rr_pick(input logic [N_VMS-1:0] req, input idx_t start);
        idx_t pick  = start;
        logic found = 1'b0;
        for (int k = 0; k < int'(N_VMS); k++) begin
            int unsigned j;
            j = (int'(start) + k) % N_VMS;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = idx_t'(j);
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Snoop FSM
    // ------------------------------------------------------------------
    s_state_e    s_state_q, s_state_d;
    idx_t        s_lock_q, s_lock_d;
    idx_t        s_ptr_q, s_ptr_d;
    logic [31:0] pkt_in_q, pkt_in_d;

    logic s_any;
    idx_t s_cand;
    idx_t s_tgt;
    logic s_tgt_ok;

    assign s_any    = |vm_ready_for_snooper;
    assign s_cand   = rr_pick(vm_ready_for_snooper, s_ptr_q);
    assign s_tgt    = (s_state_q == S_LOCK) ? s_lock_q : s_cand;
    // Once locked the target is fixed even if its ready drops mid-packet.
    assign s_tgt_ok = (s_state_q == S_LOCK) || s_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_state_q <= S_IDLE;
            s_lock_q  <= '0;
            s_ptr_q   <= '0;
            pkt_in_q  <= '0;
        end else begin
            s_state_q <= s_state_d;
            s_lock_q  <= s_lock_d;
            s_ptr_q   <= s_ptr_d;
            pkt_in_q  <= pkt_in_d;
        end
    end

    always_comb begin
        s_state_d = s_state_q;
        s_lock_d  = s_lock_q;
        s_ptr_d   = s_ptr_q;
        pkt_in_d  = pkt_in_q;
        unique case (s_state_q)
            S_IDLE: begin
                // A done here is a 1-beat or zero-length packet: complete in place.
                if (s_tgt_ok && up_done) begin
                    s_ptr_d  = inc_wrap(s_cand);
                    pkt_in_d = pkt_in_q + 32'd1;
                end else if (s_tgt_ok && up_wr_en) begin
                    s_state_d = S_LOCK;
                    s_lock_d  = s_cand;
                end
            end
            S_LOCK: begin
                if (up_done) begin
                    s_state_d = S_IDLE;
                    s_ptr_d   = inc_wrap(s_lock_q);
                    pkt_in_d  = pkt_in_q + 32'd1;
                end
            end
            default: s_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vm_wr_en = '0;
        vm_done  = '0;
        if (!rst && s_tgt_ok) begin
            vm_wr_en[s_tgt] = up_wr_en;
            vm_done[s_tgt]  = up_done;
        end
        up_ready = (s_state_q == S_LOCK) ? vm_ready_for_snooper[s_lock_q] : s_any;
    end

    assign vm_wr_addr = {N_VMS{up_wr_addr}};
    assign vm_wr_data = {N_VMS{up_wr_data}};
    assign pkt_in_cnt = pkt_in_q;

    // ------------------------------------------------------------------
    // Forward FSM
    // ------------------------------------------------------------------
    f_state_e    f_state_q, f_state_d;
    idx_t        f_lock_q, f_lock_d;
    idx_t        f_ptr_q, f_ptr_d;
    logic [31:0] pkt_out_q, pkt_out_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_state_q <= F_IDLE;
            f_lock_q  <= '0;
            f_ptr_q   <= '0;
            pkt_out_q <= '0;
        end else begin
            f_state_q <= f_state_d;
            f_lock_q  <= f_lock_d;
            f_ptr_q   <= f_ptr_d;
            pkt_out_q <= pkt_out_d;
        end
    end

    always_comb begin
        f_state_d = f_state_q;
        f_lock_d  = f_lock_q;
        f_ptr_d   = f_ptr_q;
        pkt_out_d = pkt_out_q;
        unique case (f_state_q)
            F_IDLE: begin
                if (|vm_ready_for_forwarder) begin
                    f_state_d = F_LOCK;
                    f_lock_d  = rr_pick(vm_ready_for_forwarder, f_ptr_q);
                end
            end
            F_LOCK: begin
                // f_lock is deliberately left alone so the last read beat,
                // returning the cycle after dn_done, still steers correctly.
                if (dn_done) begin
                    f_state_d = F_IDLE;
                    f_ptr_d   = inc_wrap(f_lock_q);
                    pkt_out_d = pkt_out_q + 32'd1;
                end
            end
            default: f_state_d = F_IDLE;
        endcase
    end

    always_comb begin
        vm_rd_en    = '0;
        vm_fwd_done = '0;
        dn_ready    = 1'b0;
        dn_len      = '0;
        if (!rst && f_state_q == F_LOCK) begin
            vm_rd_en[f_lock_q]    = dn_rd_en;
            vm_fwd_done[f_lock_q] = dn_done;
            dn_ready              = 1'b1;
            dn_len                = vm_len[int'(f_lock_q)*PLEN_WIDTH +: PLEN_WIDTH];
        end
    end

    assign vm_rd_addr  = dn_rd_addr;
    assign dn_rd_data  = vm_rd_data[int'(f_lock_q)*DATA_WIDTH +: DATA_WIDTH];
    assign pkt_out_cnt = pkt_out_q;

endmodule
